// File: rtl/pp_final_reduce_stage.sv
// pp_final_reduce_stage
// Final stage of the 16x16 approximate multiplier datapath. It takes the four
// partial-product rows and the correction bit from the 8-to-4 reduction layer
// and produces the 32-bit product in two pipeline stages.
//   Stage 1: the low columns (1..APPROX_COLS) go through approximate 4:2
//            compressors, giving an X row (sums) and a Y row (carries). The
//            high columns are reduced exactly to a carry-save pair.
//   Stage 2: a carry-save tree merges X, Y, the high pair and err_in, then a
//            carry-propagate add produces the product.
// Column k of every row has weight 2^(k-1); bit k of a row is column k.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   a_in, b_in, c_in,   partial-product rows A [31:1], B [30:2], C [29:3],
//   d_in                D [29:4]
//   err_in              correction bit, weight 2^APPROX_COLS
//   out_valid/out_ready output handshake
//   product             registered product, modulo 2^32
//   approx_flag         a low column had all four bits set (compressor saturated)
//   approx_cnt          saturating count of delivered results with approx_flag=1
//   cnt_clr             synchronous clear of approx_cnt, wins over an increment
module pp_final_reduce_stage #(
    parameter int unsigned APPROX_COLS = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:1]      a_in,
    input  logic [30:2]      b_in,
    input  logic [29:3]      c_in,
    input  logic [29:4]      d_in,
    input  logic             err_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      product,
    output logic             approx_flag,
    output logic [CNT_W-1:0] approx_cnt,
    input  logic             cnt_clr
);

    localparam int unsigned PW = 32;

    // Bit i set for columns 1..APPROX_COLS (bit index = column - 1).
    localparam logic [PW-1:0] LOW_MASK = PW'((64'(1) << APPROX_COLS) - 64'(1));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_load;
    logic s2_load;

    always_comb begin
        s2_load  = s1_valid & (~out_valid | out_ready);
        in_ready = ~s1_valid | s2_load;
        s1_load  = in_valid & in_ready;
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: align rows to column positions
    // ------------------------------------------------------------------
    logic [PW-1:0] a_col, b_col, c_col, d_col;

    always_comb begin
        a_col        = '0;
        b_col        = '0;
        c_col        = '0;
        d_col        = '0;
        a_col[30:0]  = a_in;
        b_col[29:1]  = b_in;
        c_col[28:2]  = c_in;
        d_col[28:3]  = d_in;
    end

    // Approximate 4:2 compression of the low columns. The sum bit is an OR of
    // the two pair-XORs and the carry is an OR of the two pair-ANDs, so a
    // column with all four bits set yields 2 instead of 4: that is the
    // saturation event reported by approx_flag.
    logic [PW-1:0] x_row_c;
    logic [PW-1:0] y_row_c;
    logic          flag_c;

    always_comb begin
        x_row_c = ((a_col ^ b_col) | (c_col ^ d_col)) & LOW_MASK;
        y_row_c = (((a_col & b_col) | (c_col & d_col)) & LOW_MASK) << 1;
        flag_c  = |(a_col & b_col & c_col & d_col & LOW_MASK);
    end

    // Exact 4:2 reduction of the high columns as two chained full-adder rows.
    logic [PW-1:0] ah, bh, ch, dh;
    logic [PW-1:0] fa1_s, fa1_c;
    logic [PW-1:0] hs_c, hc_c;

    always_comb begin
        ah    = a_col & ~LOW_MASK;
        bh    = b_col & ~LOW_MASK;
        ch    = c_col & ~LOW_MASK;
        dh    = d_col & ~LOW_MASK;
        fa1_s = ah ^ bh ^ ch;
        fa1_c = ((ah & bh) | (ah & ch) | (bh & ch)) << 1;
        hs_c  = fa1_s ^ fa1_c ^ dh;
        hc_c  = ((fa1_s & fa1_c) | (fa1_s & dh) | (fa1_c & dh)) << 1;
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic [PW-1:0] s1_x;
    logic [PW-1:0] s1_y;
    logic [PW-1:0] s1_hs;
    logic [PW-1:0] s1_hc;
    logic          s1_err;
    logic          s1_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_hs    <= '0;
            s1_hc    <= '0;
            s1_err   <= 1'b0;
            s1_flag  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_x     <= x_row_c;
                s1_y     <= y_row_c;
                s1_hs    <= hs_c;
                s1_hc    <= hc_c;
                s1_err   <= err_in;
                s1_flag  <= flag_c;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: 5-operand carry-save merge, then the CPA
    // ------------------------------------------------------------------
    logic [PW-1:0] err_vec;
    logic [PW-1:0] t1_s, t1_c;
    logic [PW-1:0] t2_s, t2_c;
    logic [PW-1:0] t3_s, t3_c;
    logic [PW-1:0] sum_c;

    always_comb begin
        err_vec = PW'(s1_err) << APPROX_COLS;
        t1_s    = s1_x ^ s1_y ^ s1_hs;
        t1_c    = ((s1_x & s1_y) | (s1_x & s1_hs) | (s1_y & s1_hs)) << 1;
        t2_s    = t1_s ^ t1_c ^ s1_hc;
        t2_c    = ((t1_s & t1_c) | (t1_s & s1_hc) | (t1_c & s1_hc)) << 1;
        t3_s    = t2_s ^ t2_c ^ err_vec;
        t3_c    = ((t2_s & t2_c) | (t2_s & err_vec) | (t2_c & err_vec)) << 1;
        sum_c   = t3_s + t3_c;
    end

    // ------------------------------------------------------------------
    // Stage 2 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            product     <= '0;
            approx_flag <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid   <= 1'b1;
                product     <= sum_c;
                approx_flag <= s1_flag;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

    // Saturating count of delivered flagged results; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            approx_cnt <= '0;
        end else if (cnt_clr) begin
            approx_cnt <= '0;
        end else if (out_valid && out_ready && approx_flag && (approx_cnt != CNT_MAX)) begin
            approx_cnt <= approx_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pp_final_reduce_stage.sv
// Self-checking bench for pp_final_reduce_stage. Two instances share stimulus:
// u_dut (CNT_W=16) and u_dut4 (CNT_W=4, for counter saturation).
module tb_pp_final_reduce_stage;

    localparam int unsigned APPROX = 16;

    typedef struct packed {
        logic [31:1] a;
        logic [30:2] b;
        logic [29:3] c;
        logic [29:4] d;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:1] a_in = '0;
    logic [30:2] b_in = '0;
    logic [29:3] c_in = '0;
    logic [29:4] d_in = '0;
    logic        err_in = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        in_ready, out_valid, approx_flag;
    logic [31:0] product;
    logic [15:0] approx_cnt;
    logic        in_ready4, out_valid4, approx_flag4;
    logic [31:0] product4;
    logic [3:0]  approx_cnt4;

    int checks = 0;
    int failures = 0;

    pp_final_reduce_stage #(.APPROX_COLS(APPROX), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .err_in(err_in),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .approx_flag(approx_flag), .approx_cnt(approx_cnt), .cnt_clr(cnt_clr)
    );

    pp_final_reduce_stage #(.APPROX_COLS(APPROX), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .err_in(err_in),
        .out_valid(out_valid4), .out_ready(out_ready), .product(product4),
        .approx_flag(approx_flag4), .approx_cnt(approx_cnt4), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    // Reference: column-by-column arithmetic straight from the product rule.
    function automatic logic [32:0] golden(input vec_t v);
        logic [32:0]     av, bv, cv, dv;
        longint unsigned sum;
        logic            flag;
        av = '0; bv = '0; cv = '0; dv = '0;
        av[31:1] = v.a; bv[30:2] = v.b; cv[29:3] = v.c; dv[29:4] = v.d;
        sum = 0;
        flag = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            longint unsigned ab, bb, cb, db;
            ab = 64'(av[k]); bb = 64'(bv[k]); cb = 64'(cv[k]); db = 64'(dv[k]);
            if (k <= int'(APPROX)) begin
                sum += ((ab ^ bb) | (cb ^ db)) << (k - 1);
                sum += ((ab & bb) | (cb & db)) << k;
                flag |= av[k] & bv[k] & cv[k] & dv[k];
            end else begin
                sum += (ab + bb + cb + db) << (k - 1);
            end
        end
        sum += 64'(v.err) << APPROX;
        return {flag, sum[31:0]};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.a   = 31'($urandom);
        v.b   = 29'($urandom);
        v.c   = 27'($urandom);
        v.d   = 26'($urandom);
        v.err = 1'($urandom);
        return v;
    endfunction

    function automatic vec_t col_vec(input int k);
        vec_t v;
        v = '0;
        v.a[k] = 1'b1; v.b[k] = 1'b1; v.c[k] = 1'b1; v.d[k] = 1'b1;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        a_in = v.a; b_in = v.b; c_in = v.c; d_in = v.d; err_in = v.err;
        in_valid = vld;
    endtask

    // Transaction recorder: accepted inputs and delivered outputs per instance.
    vec_t        acc_q[$];
    vec_t        acc4_q[$];
    logic [32:0] got_q[$];
    logic [32:0] got4_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)   acc_q.push_back(vec_t'({a_in, b_in, c_in, d_in, err_in}));
            if (in_valid && in_ready4)  acc4_q.push_back(vec_t'({a_in, b_in, c_in, d_in, err_in}));
            if (out_valid && out_ready)  got_q.push_back({approx_flag, product});
            if (out_valid4 && out_ready) got4_q.push_back({approx_flag4, product4});
        end
    end

    task automatic flush();
        acc_q.delete(); acc4_q.delete(); got_q.delete(); got4_q.delete();
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || product !== 32'h0 || approx_flag !== 1'b0 ||
            approx_cnt !== 16'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b product=%h flag=%b cnt=%0d in_ready=%b, expected 0/0/0/0/1",
                     out_valid, product, approx_flag, approx_cnt, in_ready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t        cv[6];
        logic [31:0] ep[6];
        logic        ef[6];
        logic [32:0] g;
        int          exp_cnt;
        cv[0] = '0; cv[0].a[1] = 1'b1;          ep[0] = 32'h0000_0001; ef[0] = 1'b0;
        cv[1] = col_vec(5);                      ep[1] = 32'h0000_0020; ef[1] = 1'b1;
        cv[2] = col_vec(20);                     ep[2] = 32'h0020_0000; ef[2] = 1'b0;
        cv[3] = '0; cv[3].err = 1'b1;            ep[3] = 32'h0001_0000; ef[3] = 1'b0;
        cv[4] = col_vec(16);                     ep[4] = 32'h0001_0000; ef[4] = 1'b1;
        cv[5] = '1;
        g = golden(cv[5]);                       ep[5] = g[31:0];       ef[5] = g[32];
        exp_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; drive(cv[i], 1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_accept: in_ready=%b expected 1", i, in_ready);
            end
            // Scramble data after the handshake; it must not matter.
            @(posedge clk); #1; drive(rand_vec(), 1'b0);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_latency_early: out_valid=%b expected 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || product !== ep[i] || approx_flag !== ef[i]) begin
                failures++;
                $display("FAIL dir%0d_result: valid=%b product=%h flag=%b expected valid=1 product=%h flag=%b",
                         i, out_valid, product, approx_flag, ep[i], ef[i]);
            end
            @(negedge clk);
            exp_cnt += int'(ef[i]);
            checks++;
            if (approx_cnt !== 16'(exp_cnt) || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_count: cnt=%0d valid=%b expected cnt=%0d valid=0",
                         i, approx_cnt, out_valid, exp_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t        bv[4];
        logic [32:0] g;
        int          n;
        for (int i = 0; i < 4; i++) bv[i] = rand_vec();
        flush();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            n = acc_q.size();
            if (n < 4) drive(bv[n], 1'b1); else in_valid = 1'b0;
        end
        @(negedge clk);
        g = golden(bv[0]);
        checks++;
        if (acc_q.size() != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
            product !== g[31:0] || got_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_stall: accepts=%0d in_ready=%b out_valid=%b product=%h delivered=%0d expected 2/0/1/%h/0",
                     acc_q.size(), in_ready, out_valid, product, got_q.size(), g[31:0]);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got_q.size() < 4; cyc++) begin
            @(posedge clk); #1;
            n = acc_q.size();
            if (n < 4) drive(bv[n], 1'b1); else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL backpressure_count: delivered=%0d expected 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                g = golden(bv[i]);
                checks++;
                if (got_q[i] !== g) begin
                    failures++;
                    $display("FAIL backpressure_order%0d: got %h expected %h", i, got_q[i], g);
                end
            end
        end
    endtask

    task automatic test_random();
        int          nflag;
        logic [32:0] g;
        int          cyc;
        repeat (3) @(negedge clk);
        pulse_clr();
        flush();
        cyc = 0;
        while ((got_q.size() < 1000 || got4_q.size() < 1000) && cyc < 20000) begin
            @(posedge clk); #1;
            drive(rand_vec(), (acc_q.size() < 1000) && ($urandom_range(3) != 0));
            out_ready = ($urandom_range(3) != 0) || (acc_q.size() >= 1000);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (acc_q.size() != 1000 || got_q.size() != 1000 || acc4_q.size() != 1000 || got4_q.size() != 1000) begin
            failures++;
            $display("FAIL random_count: acc=%0d got=%0d acc4=%0d got4=%0d expected 1000 each",
                     acc_q.size(), got_q.size(), acc4_q.size(), got4_q.size());
        end else begin
            nflag = 0;
            for (int i = 0; i < 1000; i++) begin
                g = golden(acc_q[i]);
                nflag += int'(g[32]);
                checks++;
                if (got_q[i] !== g) begin
                    failures++;
                    $display("FAIL random_vec%0d: got %h expected %h", i, got_q[i], g);
                end
                g = golden(acc4_q[i]);
                checks++;
                if (got4_q[i] !== g) begin
                    failures++;
                    $display("FAIL random4_vec%0d: got %h expected %h", i, got4_q[i], g);
                end
            end
            checks++;
            if (approx_cnt !== 16'(nflag) || approx_cnt4 !== 4'((nflag > 15) ? 15 : nflag)) begin
                failures++;
                $display("FAIL random_counter: cnt=%0d cnt4=%0d expected %0d and %0d",
                         approx_cnt, approx_cnt4, nflag, (nflag > 15) ? 15 : nflag);
            end
        end
    endtask

    task automatic test_saturation();
        repeat (3) @(negedge clk);
        pulse_clr();
        @(negedge clk);
        checks++;
        if (approx_cnt !== 16'h0 || approx_cnt4 !== 4'h0) begin
            failures++;
            $display("FAIL sat_clear: cnt=%0d cnt4=%0d expected 0", approx_cnt, approx_cnt4);
        end
        flush();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got_q.size() < 20; cyc++) begin
            @(posedge clk); #1;
            drive(col_vec(5), acc_q.size() < 20);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (approx_cnt !== 16'd20 || approx_cnt4 !== 4'd15) begin
            failures++;
            $display("FAIL sat_count: cnt=%0d cnt4=%0d expected 20 and 15", approx_cnt, approx_cnt4);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        repeat (3) @(negedge clk);
        flush();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 20 && acc_q.size() < 2; cyc++) begin
            @(posedge clk); #1;
            drive(col_vec(5), 1'b1);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || approx_cnt !== 16'd20) begin
            failures++;
            $display("FAIL midreset_full: out_valid=%b in_ready=%b cnt=%0d expected 1/0/20",
                     out_valid, in_ready, approx_cnt);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || approx_cnt !== 16'h0 || approx_cnt4 !== 4'h0 ||
            product !== 32'h0 || approx_flag !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async: out_valid=%b cnt=%0d cnt4=%0d product=%h flag=%b in_ready=%b expected 0/0/0/0/0/1",
                     out_valid, approx_cnt, approx_cnt4, product, approx_flag, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        rst = 1'b0;
        flush();
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1 || out_valid4 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || got_q.size() != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_discard: valid_cycles=%0d delivered=%0d in_ready=%b expected 0/0/1",
                     seen, got_q.size(), in_ready);
        end
    endtask

    task automatic test_cnt_clr();
        flush();
        out_ready = 1'b1;
        @(posedge clk); #1; drive(col_vec(5), 1'b1);
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (approx_cnt !== 16'd1 || approx_cnt4 !== 4'd1) begin
            failures++;
            $display("FAIL clr_pre: cnt=%0d cnt4=%0d expected 1", approx_cnt, approx_cnt4);
        end
        @(posedge clk); #1; drive(col_vec(16), 1'b1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || approx_flag !== 1'b1) begin
            failures++;
            $display("FAIL clr_coincide_delivery: out_valid=%b flag=%b expected 1/1", out_valid, approx_flag);
        end
        @(posedge clk); #1; cnt_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (approx_cnt !== 16'h0 || approx_cnt4 !== 4'h0) begin
            failures++;
            $display("FAIL clr_priority: cnt=%0d cnt4=%0d expected 0", approx_cnt, approx_cnt4);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_midflight();
        test_cnt_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pp_final_reduce_stage.md
Name: pp_final_reduce_stage

Overview:
- Final stage of the 16x16 approximate multiplier datapath; sits directly downstream of the 8-to-4 row reduction layer.
- Consumes that layer's four partial-product rows and its error/correction bit.
- Reduces the rows to two (approximate compressors in the low columns, exact addition above), then performs the final carry-propagate add to the 32-bit product.
- Two-stage pipeline with valid/ready handshake and a saturating approximation-event counter.

Parameters:
- APPROX_COLS, 16, columns 1..APPROX_COLS use approximate 4:2 compression; err_in is injected at column APPROX_COLS+1; legal range 4..28.
- CNT_W, 16, width of approx_cnt.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  row set and err_in are valid.
- in_ready  output  1  stage can accept input this cycle.
- a_in  input  [31:1]  row A; bit k has weight 2^(k-1).
- b_in  input  [30:2]  row B.
- c_in  input  [29:3]  row C.
- d_in  input  [29:4]  row D.
- err_in  input  1  correction bit from the upstream layer, weight 2^APPROX_COLS.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  32  result, modulo 2^32.
- approx_flag  output  1  at least one low column saturated the approximate compressor.
- approx_cnt  output  CNT_W  count of delivered results with approx_flag=1, saturating.
- cnt_clr  input  1  synchronous clear of approx_cnt.

Behaviour:
- Golden model: for column k <= APPROX_COLS, take bits a,b,c,d (missing bits = 0).
  - S_k = (a^b)|(c^d), weight 2^(k-1).
  - C_k = (a&b)|(c&d), weight 2^k.
  - H = exact sum of all row bits in columns > APPROX_COLS.
  - product = (sum S_k + sum C_k + H + err_in*2^APPROX_COLS) mod 2^32.
  - C_APPROX_COLS lands in column APPROX_COLS+1 and is added exactly.
- approx_flag = OR over k <= APPROX_COLS of (a&b&c&d) in column k.
- Stage 1 register holds:
  - X row (S bits),
  - Y row (C bits),
  - the exact high-column carry-save pair,
  - err_in and approx_flag,
  - s1_valid.
- Stage 2 register holds product, approx_flag and out_valid. The CPA runs between stage 1 and stage 2.
- Stage advance rules:
  - s2_load = s1_valid & (!out_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = !s1_valid | s2_load (combinational).
  - If stage 1 empties without reloading, s1_valid clears.
  - If out_ready is high and nothing loads, out_valid clears.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput 1 per cycle.
- Stall: outputs hold stable while out_valid & !out_ready. At most 2 transactions in flight; in_ready=0 when both stages are full and out_ready=0.
- No loss or duplication under any in_valid/out_ready pattern.
- approx_cnt increments on out_valid & out_ready & approx_flag, saturating at 2^CNT_W-1.
  - cnt_clr has priority: a clear coinciding with an increment yields 0.
- Reset (asynchronous, any time including mid-transfer):
  - s1_valid=0, out_valid=0, product=0, approx_flag=0, approx_cnt=0.
  - In-flight data is discarded.
  - in_ready=1 one cycle after rst deasserts (combinationally 1 while empty).
- Inputs are sampled only on a handshake. Data changes while in_valid=0 have no effect.

Test Plan:
- Single bit a_in[1]=1, all else 0, err_in=0 → product=0x00000001, approx_flag=0, out_valid exactly 2 cycles after accept.
- a_in[5]=b_in[5]=c_in[5]=d_in[5]=1 → product=0x00000020 (exact would be 0x40), approx_flag=1. On delivery approx_cnt 0→1.
- a_in[20]=b_in[20]=c_in[20]=d_in[20]=1 → product=0x00200000, approx_flag=0. err_in=1 alone → product=0x00010000.
- All four bits set at column 16 → product=0x00010000, approx_flag=1. Rows all-ones plus err_in=1 → product equals the golden model mod 2^32 (wraps correctly).
- Backpressure: 4 back-to-back inputs, out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts.
  - On release, products emerge in order with no duplicates.
  - 1000 random vectors with random in_valid/out_ready match the golden model.
- Reset and counter:
  - rst pulsed with both stages full → out_valid=0 and approx_cnt=0 immediately, nothing emerges afterwards.
  - CNT_W=4 with 20 flagged deliveries → approx_cnt=15.
  - cnt_clr coincident with a flagged delivery → 0.
